// File: rtl/crossbar_switch_arb.sv
// crossbar_switch_arb: registered N_IN x N_OUT crossbar with per-output round-robin arbitration
// and a one-entry output slot. `define CROSSBAR_DROP_CNT_EN adds a saturating drop_cnt port.

module crossbar_switch_arb_slot #(
  parameter int N_IN  = 3,
  parameter int WIDTH = 8,
  parameter int SW    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_IN-1:0]             req_i,
  input  logic [N_IN-1:0][WIDTH-1:0]  din_i,
  input  logic                        out_ready_i,
  output logic [N_IN-1:0]             gnt_o,
  output logic [WIDTH-1:0]            data_o,
  output logic [SW-1:0]               src_o,
  output logic                        valid_o
);
  logic [SW-1:0]    ptr_q, ptr_d, sel;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    src_q;
  logic             valid_q;
  logic             hit, load, xfer;

  // first requester at or after ptr_q, wrapping modulo N_IN
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < N_IN; k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= N_IN) idx = idx - N_IN;
      if (!hit && req_i[SW'(idx)]) begin
        hit = 1'b1;
        sel = SW'(idx);
      end
    end
  end

  assign load  = !valid_q || out_ready_i;
  assign xfer  = hit && load;
  assign gnt_o = xfer ? (N_IN'(1) << sel) : '0;
  assign ptr_d = (32'(sel) == N_IN - 1) ? '0 : sel + SW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      ptr_q   <= ptr_d;
      data_q  <= din_i[sel];
      src_q   <= sel;
      valid_q <= 1'b1;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign src_o   = src_q;
  assign valid_o = valid_q;
endmodule

module crossbar_switch_arb #(
  parameter  int N_IN  = 3,
  parameter  int N_OUT = 3,
  parameter  int WIDTH = 8,
  localparam int DW    = $clog2(N_OUT),
  localparam int SW    = $clog2(N_IN)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  input  logic [N_IN*DW-1:0]     in_dest,
  input  logic [N_IN-1:0]        in_valid,
  output logic [N_IN-1:0]        in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT*SW-1:0]    out_src,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready
`ifdef CROSSBAR_DROP_CNT_EN
  , output logic [15:0]          drop_cnt
`endif
);
  logic [N_IN-1:0][WIDTH-1:0]  din;
  logic [N_IN-1:0][DW-1:0]     dst;
  logic [N_OUT-1:0][N_IN-1:0]  req, gnt;
  logic [N_OUT-1:0][WIDTH-1:0] od;
  logic [N_OUT-1:0][SW-1:0]    os;
  logic [N_IN-1:0]             bad, granted;

  assign din = in_data;
  assign dst = in_dest;

  always_comb begin
    req = '0;
    bad = '0;
    for (int i = 0; i < N_IN; i++) begin
      bad[i] = 32'(dst[i]) >= N_OUT;
      for (int o = 0; o < N_OUT; o++)
        req[o][i] = in_valid[i] && (32'(dst[i]) == o);
    end
  end

  always_comb begin
    granted = '0;
    for (int o = 0; o < N_OUT; o++) granted = granted | gnt[o];
  end

  // out-of-range destinations are swallowed without touching any slot
  assign in_ready = {N_IN{rst_n}} & (bad | granted);

  for (genvar o = 0; o < N_OUT; o++) begin : g_out
    crossbar_switch_arb_slot #(.N_IN(N_IN), .WIDTH(WIDTH), .SW(SW)) u_slot (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_i       (req[o]),
      .din_i       (din),
      .out_ready_i (out_ready[o]),
      .gnt_o       (gnt[o]),
      .data_o      (od[o]),
      .src_o       (os[o]),
      .valid_o     (out_valid[o])
    );
  end

  assign out_data = od;
  assign out_src  = os;

`ifdef CROSSBAR_DROP_CNT_EN
  localparam int CW = $clog2(N_IN + 1);
  logic [CW-1:0] ndrop;
  logic [16:0]   dsum;
  logic [15:0]   drop_cnt_q;

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < N_IN; i++)
      if (in_valid[i] && bad[i]) ndrop = ndrop + CW'(1);
    dsum = 17'(drop_cnt_q) + 17'(ndrop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= dsum[16] ? 16'hFFFF : dsum[15:0];
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule
